fft_accel_ctrl: RTL and testbench

- Accelerator-side responder for the CPU's FFT command interface.
- The decode stage issues startF, startI and loadF and stalls on fftCalculating. This block accepts those commands and sequences the work:
  - load signal samples from memory by beat,
  - kick the FFT engine and wait for it,
  - write results back,
  - pulse done.
- Sits between decode/execute and the memory controller and FFT engine.

---
 rtl/fft_ctrl_pkg.sv | 24 ++
 rtl/fft_accel_ctrl_if.sv | 23 ++
 rtl/fft_beat_addr_gen.sv | 44 ++++
 rtl/fft_accel_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fft_accel_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT accelerator controller.
// The LOAD_FILT state exists only when FFT_FILTER_EN is defined.
package fft_ctrl_pkg;

    localparam int unsigned SIG_SHIFT = 12;

    typedef enum logic [2:0] {
        StIdle,
        StLoadSig,
        StCalcStart,
        StCalcWait,
        StWriteback,
        StDone
`ifdef FFT_FILTER_EN
        , StLoadFilt
`endif
    } fftState_e;

    // Beat-counter width, never below one bit.
    function automatic int unsigned cntWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_accel_ctrl_if.sv
// Memory-beat and FFT-engine handshake bundle driven by fft_accel_ctrl.
interface fft_accel_ctrl_if;

    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic        memAck;
    logic        engStart;
    logic        engInverse;
    logic        engFilter;
    logic        engDone;

    modport master (
        output memReq, memWe, memAddr, engStart, engInverse, engFilter,
        input  memAck, engDone
    );

    modport slave (
        input  memReq, memWe, memAddr, engStart, engInverse, engFilter,
        output memAck, engDone
    );

endinterface

// File: rtl/fft_beat_addr_gen.sv
// Beat counter and byte-address generator for one memory burst of NUM_BEATS beats.
module fft_beat_addr_gen
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BEATS  = 64,
    parameter int unsigned BEAT_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] base,
    input  logic [17:0] sigNum,
    input  logic        advance,
    input  logic        clear,
    output logic [31:0] memAddr,
    output logic        lastBeat
);

    localparam int unsigned CNT_W = cntWidth(NUM_BEATS);

    logic [CNT_W-1:0] beatCntQ, beatCntD;

    assign lastBeat = (32'(beatCntQ) == NUM_BEATS - 1);

    // The counter wraps itself on the final ack so the next burst starts at beat 0.
    always_comb begin
        beatCntD = beatCntQ;
        if (clear) begin
            beatCntD = '0;
        end else if (advance) begin
            beatCntD = lastBeat ? '0 : beatCntQ + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beatCntQ <= '0;
        end else begin
            beatCntQ <= beatCntD;
        end
    end

    assign memAddr = base + (32'(sigNum) << SIG_SHIFT) + 32'(beatCntQ) * BEAT_BYTES;

endmodule

// File: rtl/fft_accel_ctrl.sv
// FFT command responder: load signal beats, run the engine, write results back, pulse done.
// Define FFT_FILTER_EN to enable filter-coefficient loading (loadF / engFilter).
module fft_accel_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BEATS   = 64,
    parameter int unsigned BEAT_BYTES  = 64,
    parameter logic [31:0] SIG_BASE    = 32'h1000_0000,
    parameter logic [31:0] FILTER_BASE = 32'h0FFF_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              startF,
    input  logic              startI,
    input  logic              loadF,
    input  logic [17:0]       sigNum,
    output logic              fftCalculating,
    output logic              done,
    fft_accel_ctrl_if.master  bus
);

    fftState_e   stateQ, stateD;
    logic [17:0] sigNumQ, sigNumD;
    logic        inverseQ, inverseD;
    logic        memReq, memWe, engStart, engHold;
    logic        advance, lastBeat, filtPhase;
    logic [31:0] rawAddr;

`ifdef FFT_FILTER_EN
    logic filterArmedQ, filterArmedD;
    logic filtJobQ, filtJobD;
    assign filtPhase = (stateQ == StLoadFilt);
`else
    logic unusedLoadF;
    assign unusedLoadF = loadF;
    assign filtPhase   = 1'b0;
`endif

    assign advance = memReq & bus.memAck;

    fft_beat_addr_gen #(
        .NUM_BEATS  (NUM_BEATS),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .base     (filtPhase ? FILTER_BASE : SIG_BASE),
        .sigNum   (filtPhase ? 18'd0 : sigNumQ),
        .advance  (advance),
        .clear    (stateQ == StIdle),
        .memAddr  (rawAddr),
        .lastBeat (lastBeat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ       <= StIdle;
            sigNumQ      <= '0;
            inverseQ     <= 1'b0;
`ifdef FFT_FILTER_EN
            filterArmedQ <= 1'b0;
            filtJobQ     <= 1'b0;
`endif
        end else begin
            stateQ       <= stateD;
            sigNumQ      <= sigNumD;
            inverseQ     <= inverseD;
`ifdef FFT_FILTER_EN
            filterArmedQ <= filterArmedD;
            filtJobQ     <= filtJobD;
`endif
        end
    end

    always_comb begin
        stateD       = stateQ;
        sigNumD      = sigNumQ;
        inverseD     = inverseQ;
`ifdef FFT_FILTER_EN
        filterArmedD = filterArmedQ;
        filtJobD     = filtJobQ;
`endif
        unique case (stateQ)
            StIdle: begin
                if (startF || startI) begin
                    stateD   = StLoadSig;
                    sigNumD  = sigNum;
                    inverseD = !startF;
`ifdef FFT_FILTER_EN
                    filtJobD = 1'b0;
                end else if (loadF) begin
                    stateD   = StLoadFilt;
                    sigNumD  = sigNum;
                    inverseD = 1'b0;
                    filtJobD = 1'b1;
`endif
                end
            end
            StLoadSig:   if (advance && lastBeat) stateD = StCalcStart;
            StCalcStart: stateD = StCalcWait;
            StCalcWait:  if (bus.engDone) stateD = StWriteback;
            StWriteback: if (advance && lastBeat) stateD = StDone;
            StDone: begin
                stateD = StIdle;
`ifdef FFT_FILTER_EN
                // A finished filter load keeps the arm; a finished FFT consumes it.
                if (!filtJobQ) filterArmedD = 1'b0;
`endif
            end
`ifdef FFT_FILTER_EN
            StLoadFilt: begin
                if (advance && lastBeat) begin
                    stateD       = StDone;
                    filterArmedD = 1'b1;
                end
            end
`endif
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        memReq   = 1'b0;
        memWe    = 1'b0;
        engStart = 1'b0;
        engHold  = 1'b0;
        done     = 1'b0;
        unique case (stateQ)
            StLoadSig:   memReq = 1'b1;
            StCalcStart: begin
                engStart = 1'b1;
                engHold  = 1'b1;
            end
            StCalcWait:  engHold = 1'b1;
            StWriteback: begin
                memReq  = 1'b1;
                memWe   = 1'b1;
                engHold = 1'b1;
            end
            StDone: begin
                done = 1'b1;
`ifdef FFT_FILTER_EN
                engHold = !filtJobQ;
`else
                engHold = 1'b1;
`endif
            end
`ifdef FFT_FILTER_EN
            StLoadFilt:  memReq = 1'b1;
`endif
            default: ;
        endcase
    end

    assign fftCalculating = (stateQ != StIdle);
    assign bus.memReq     = memReq;
    assign bus.memWe      = memWe;
    assign bus.memAddr    = memReq ? rawAddr : 32'd0;
    assign bus.engStart   = engStart;
    assign bus.engInverse = engHold & inverseQ;
`ifdef FFT_FILTER_EN
    assign bus.engFilter  = engHold & filterArmedQ;
`else
    assign bus.engFilter  = 1'b0;
`endif

endmodule

// File: tb/tb_fft_accel_ctrl.sv
// Self-checking bench for fft_accel_ctrl with NUM_BEATS=4; filter tests follow FFT_FILTER_EN.
module tb_fft_accel_ctrl;

    localparam int unsigned NB          = 4;
    localparam logic [31:0] SIG_BASE    = 32'h1000_0000;
    localparam logic [31:0] FILTER_BASE = 32'h0FFF_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        startF, startI, loadF;
    logic [17:0] sigNum;
    logic        fftCalculating, done;

    fft_accel_ctrl_if bus ();

    fft_accel_ctrl #(
        .NUM_BEATS   (NB),
        .BEAT_BYTES  (64),
        .SIG_BASE    (SIG_BASE),
        .FILTER_BASE (FILTER_BASE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .startF         (startF),
        .startI         (startI),
        .loadF          (loadF),
        .sigNum         (sigNum),
        .fftCalculating (fftCalculating),
        .done           (done),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    beat_t       expBeats[$];
    logic [1:0]  expEng[$];
    logic [31:0] obsAddr[$];
    logic        obsWe[$];
    logic        obsInv[$];
    int          doneCnt = 0;
    int          engStartCnt = 0;
    int          ackMode = 0;
    int          ackCnt = 0;
    logic        window = 1'b0, curInv = 1'b0, curFilt = 1'b0, prevStall = 1'b0;
    logic [31:0] prevAddr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beatAddr(input logic [31:0] base, input int unsigned sig,
                                            input int unsigned i);
        return base + sig * 4096 + i * 64;
    endfunction

    // Scoreboard: every accepted beat, engine start and engine-select level.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prevStall = 1'b0;
                window    = 1'b0;
                continue;
            end
            if (bus.memReq && prevStall) check("memAddr stable", bus.memAddr, prevAddr);
            if (bus.memReq && bus.memAck) begin
                beat_t b;
                obsAddr.push_back(bus.memAddr);
                obsWe.push_back(bus.memWe);
                if (expBeats.size() == 0) begin
                    check("unexpected beat", 1, 0);
                end else begin
                    b = expBeats.pop_front();
                    check("beat addr", bus.memAddr, b.addr);
                    check("beat we", bus.memWe, b.we);
                end
            end
            prevStall = bus.memReq && !bus.memAck;
            prevAddr  = bus.memAddr;
            if (bus.engStart) begin
                logic [1:0] e;
                engStartCnt++;
                obsInv.push_back(bus.engInverse);
                if (expEng.size() == 0) begin
                    check("unexpected engStart", 1, 0);
                end else begin
                    e       = expEng.pop_front();
                    window  = 1'b1;
                    curInv  = e[1];
                    curFilt = e[0];
                    check("writes pending at engStart", expBeats.size(), NB);
                end
            end
            check("engInverse", bus.engInverse, window ? curInv : 1'b0);
            check("engFilter", bus.engFilter, window ? curFilt : 1'b0);
            if (done) begin
                doneCnt++;
                window = 1'b0;
            end
        end
    end

    initial begin
        bus.memAck = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ackCnt++;
            bus.memAck = (ackMode == 0) ? 1'b1 : ((ackCnt % 3) == 0);
        end
    end

    initial begin
        bus.engDone = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.engStart) begin
                repeat (10) @(posedge clk);
                #1 bus.engDone = 1'b1;
                @(posedge clk);
                #1 bus.engDone = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulseCmd(input logic f, input logic i, input logic l, input logic [17:0] s);
        @(posedge clk);
        #1;
        startF = f;
        startI = i;
        loadF  = l;
        sigNum = s;
        @(posedge clk);
        #1;
        startF = 1'b0;
        startI = 1'b0;
        loadF  = 1'b0;
        sigNum = s ^ 18'h3FFFF;
    endtask

    task automatic waitDone(input string name, input bit inject);
        int  n    = 0;
        bit  seen = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
            else check({name, " busy"}, fftCalculating, 1);
            if (inject && bus.engStart) begin
                repeat (3) @(posedge clk);
                #1 startI = 1'b1;
                sigNum = 18'd9;
                @(posedge clk);
                #1 startI = 1'b0;
                n += 4;
            end
        end
        if (!seen) check({name, " done timeout"}, 0, 1);
        @(posedge clk);
        #1;
        check({name, " idle after done"}, fftCalculating, 0);
        check({name, " beats left"}, expBeats.size(), 0);
    endtask

    task automatic runFft(input string name, input logic f, input logic i, input logic l,
                          input logic [17:0] s, input bit expInv, input bit expFilt,
                          input bit inject);
        int d0;
        for (int k = 0; k < NB; k++) expBeats.push_back('{addr: beatAddr(SIG_BASE, s, k), we: 1'b0});
        for (int k = 0; k < NB; k++) expBeats.push_back('{addr: beatAddr(SIG_BASE, s, k), we: 1'b1});
        expEng.push_back({expInv, expFilt});
        obsAddr.delete();
        obsWe.delete();
        obsInv.delete();
        d0 = doneCnt;
        pulseCmd(f, i, l, s);
        check({name, " busy after cmd"}, fftCalculating, 1);
        waitDone(name, inject);
        check({name, " one done"}, doneCnt, d0 + 1);
    endtask

    initial begin
        int d0;
        int nRd;
        int nWr;
        int n;
        bit found;
        int starts0;

        rst_n  = 1'b0;
        startF = 1'b1;
        startI = 1'b0;
        loadF  = 1'b0;
        sigNum = 18'd2;
        #1;
        check("rst fftCalculating", fftCalculating, 0);
        check("rst done", done, 0);
        check("rst memReq", bus.memReq, 0);
        check("rst memWe", bus.memWe, 0);
        check("rst memAddr", bus.memAddr, 0);
        check("rst engStart", bus.engStart, 0);
        check("rst engInverse", bus.engInverse, 0);
        check("rst engFilter", bus.engFilter, 0);
        repeat (2) @(posedge clk);
        #1 startF = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle after reset", fftCalculating, 0);
        end

        // Forward FFT, memAck always high.
        runFft("fwd", 1, 0, 0, 18'd2, 0, 0, 0);
        check("fwd beat count", obsAddr.size(), 2 * NB);
        if (obsAddr.size() >= 8) begin
            check("fwd rd0", obsAddr[0], 32'h1000_2000);
            check("fwd rd1", obsAddr[1], 32'h1000_2040);
            check("fwd rd2", obsAddr[2], 32'h1000_2080);
            check("fwd rd3", obsAddr[3], 32'h1000_20C0);
            check("fwd wr0", obsAddr[4], 32'h1000_2000);
            check("fwd wr3", obsAddr[7], 32'h1000_20C0);
            check("fwd we3", obsWe[3], 0);
            check("fwd we4", obsWe[4], 1);
        end
        check("fwd engStarts", obsInv.size(), 1);
        if (obsInv.size() >= 1) check("fwd engInverse", obsInv[0], 0);

        // Inverse FFT with memAck every third cycle.
        ackMode = 1;
        runFft("inv", 0, 1, 0, 18'd5, 1, 0, 0);
        ackMode = 0;
        nRd = 0;
        nWr = 0;
        foreach (obsWe[k]) if (obsWe[k]) nWr++; else nRd++;
        check("inv reads", nRd, 4);
        check("inv writes", nWr, 4);
        if (obsAddr.size() >= 1) check("inv rd0", obsAddr[0], 32'h1000_5000);
        if (obsInv.size() >= 1) check("inv engInverse", obsInv[0], 1);

        // All three commands at once, plus a startI while the engine runs.
        starts0 = engStartCnt;
        runFft("prio", 1, 1, 1, 18'd1, 0, 0, 1);
        if (obsAddr.size() >= 1) check("prio rd0", obsAddr[0], 32'h1000_1000);
        repeat (30) @(negedge clk);
        check("prio no second job", fftCalculating, 0);
        check("prio engStarts", engStartCnt, starts0 + 1);

`ifdef FFT_FILTER_EN
        for (int k = 0; k < NB; k++) expBeats.push_back('{addr: beatAddr(FILTER_BASE, 0, k), we: 1'b0});
        obsAddr.delete();
        d0 = doneCnt;
        pulseCmd(0, 0, 1, 18'd6);
        check("filt busy after cmd", fftCalculating, 1);
        waitDone("filt", 0);
        check("filt one done", doneCnt, d0 + 1);
        check("filt beat count", obsAddr.size(), NB);
        if (obsAddr.size() >= 4) begin
            check("filt rd0", obsAddr[0], 32'h0FFF_0000);
            check("filt rd3", obsAddr[3], 32'h0FFF_00C0);
        end
        runFft("filtInv", 0, 1, 0, 18'd3, 1, 1, 0);
        runFft("filtClr", 1, 0, 0, 18'd0, 0, 0, 0);
`else
        pulseCmd(0, 0, 1, 18'd4);
        repeat (10) begin
            @(negedge clk);
            check("loadF ignored", fftCalculating, 0);
        end
`endif

        // Reset during the third write-back beat.
        for (int k = 0; k < NB; k++) expBeats.push_back('{addr: beatAddr(SIG_BASE, 7, k), we: 1'b0});
        for (int k = 0; k < NB; k++) expBeats.push_back('{addr: beatAddr(SIG_BASE, 7, k), we: 1'b1});
        expEng.push_back(2'b00);
        pulseCmd(1, 0, 0, 18'd7);
        n = 0;
        found = 0;
        while (!found && n < 300) begin
            @(negedge clk);
            n++;
            if (bus.memReq && bus.memWe && bus.memAddr == beatAddr(SIG_BASE, 7, 2)) found = 1;
        end
        check("midrst reached wb beat 2", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst memReq async", bus.memReq, 0);
        check("midrst fftCalculating", fftCalculating, 0);
        d0 = doneCnt;
        expBeats.delete();
        expEng.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("midrst idle", fftCalculating, 0);
        end
        check("midrst no done", doneCnt, d0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
